// File: rtl/fpu_pkg.sv
// Shared FPU constants and stage-register types.
// Used by the integer-to-float conversion pipe.
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;

  // Exponent of a value whose leading one sits at bit 31
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + 31);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float32_t;

  typedef struct packed {
    logic        vld;
    logic        sign;
    logic [31:0] mag;
  } s1_t;

  typedef struct packed {
    logic        vld;
    logic        sign;
    logic        zero;
    logic [5:0]  lzc;
    logic [30:0] norm;
  } s2_t;

  typedef struct packed {
    logic     vld;
    float32_t res;
  } s3_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter.
// An all-zero input reports 32.
module lzc32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_cnt
);

  always_comb begin
    o_cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_cnt = 6'(31 - i);
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 to float32 converter, RNE.
// Whole pipe advances together; stall comes from the output.
module itof_pipe
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  s1_t r_s1;
  s2_t r_s2;
  s3_t r_s3;

  logic        w_adv;
  logic [31:0] w_mag;
  logic [5:0]  w_lzc;
  logic        w_rnd;
  logic [23:0] w_man_sum;
  logic [7:0]  w_exp;
  float32_t    w_res;

  assign w_adv     = !r_s3.vld | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_s3.vld;
  assign out_data  = r_s3.res;

  assign w_mag = in_data[31] ? (~in_data + 32'd1) : in_data;

  lzc32 u_lzc (
    .i_data (r_s1.mag),
    .o_cnt  (w_lzc)
  );

  // Guard/sticky/lsb sit just below the 23 kept bits
  assign w_rnd = r_s2.norm[7] &
                 ((|r_s2.norm[6:0]) | r_s2.norm[8]);

  assign w_man_sum = {1'b0, r_s2.norm[30:8]} +
                     {23'd0, w_rnd};

  assign w_exp = EXP_TOP - {2'b00, r_s2.lzc} +
                 {7'd0, w_man_sum[23]};

  always_comb begin
    w_res = '0;
    if (!r_s2.zero) begin
      w_res.sign = r_s2.sign;
      w_res.exp  = w_exp;
      w_res.man  = w_man_sum[22:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else if (w_adv) begin
      r_s1.vld <= in_valid;
      if (in_valid) begin
        r_s1.sign <= in_data[31];
        r_s1.mag  <= w_mag;
      end
      r_s2.vld <= r_s1.vld;
      if (r_s1.vld) begin
        r_s2.sign <= r_s1.sign;
        r_s2.zero <= (r_s1.mag == 32'd0);
        r_s2.lzc  <= w_lzc;
        r_s2.norm <= 31'(r_s1.mag << w_lzc);
      end
      r_s3.vld <= r_s2.vld;
      if (r_s2.vld) r_s3.res <= w_res;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Scoreboard bench for itof_pipe.
// Expected floats come from an integer rounding model.
module tb_itof_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  itof_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_f(input logic [31:0] x);
    logic [31:0] a;
    logic [63:0] m, q, rem, half;
    int p, sh;
    if (x == 32'd0) return 32'd0;
    a = x[31] ? (~x + 32'd1) : x;
    m = {32'd0, a};
    p = 31;
    while (m[p] == 1'b0) p--;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh = p - 23;
      q = m >> sh;
      rem = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[24]) begin
        q = q >> 1;
        p++;
      end
    end
    return {x[31], 8'(127 + p), q[22:0]};
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_out_data: got %h expected 0", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] exps[4] = '{32'h0, 32'h3F800000, 32'hBF800000, 32'h4F000000};
    logic [31:0] e;
    int k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (k < 4);
      if (k < 4) in_data = vals[k];
      #1;
      checks++;
      if (out_valid !== (c >= 3 && c <= 6)) begin
        failures++;
        $display("FAIL b2b_latency: cycle %0d out_valid=%b", c, out_valid);
      end
      if (out_valid && out_ready) begin
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
        checks++;
        if (out_data !== e) begin
          failures++;
          $display("FAIL b2b_data: got %h expected %h", out_data, e);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(exps[k]);
        k++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_rounding();
    logic [31:0] vals[3] = '{32'h80000000, 32'd16777217, 32'd16777219};
    logic [31:0] exps[3] = '{32'hCF000000, 32'h4B800000, 32'h4B800002};
    logic [31:0] e;
    int k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = (k < 3);
      if (k < 3) in_data = vals[k];
      #1;
      if (out_valid && out_ready) begin
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
        checks++;
        if (out_data !== e) begin
          failures++;
          $display("FAIL round_data: got %h expected %h", out_data, e);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(exps[k]);
        k++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (sb.size() != 0 || k != 3) begin
      failures++;
      $display("FAIL round_drain: left %0d sent %0d expected 0 3", sb.size(), k);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals[5] = '{32'd100, 32'hFFFFFFF9, 32'd12345678,
                             32'h00FFFFFF, 32'd33554435};
    logic [31:0] held, e;
    logic stall;
    int s = -1;
    int k = 0;
    int got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      if (s < 0 && out_valid) begin
        s = c;
        held = out_data;
      end
      stall = (s >= 0 && c < s + 4);
      out_ready = !stall;
      in_valid = (k < 5);
      if (k < 5) in_data = vals[k];
      #1;
      if (stall) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          failures++;
          $display("FAIL bp_hold: got %b/%h expected 1/%h", out_valid, out_data, held);
        end
      end
      if (out_valid && out_ready) begin
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
        got++;
        checks++;
        if (out_data !== e) begin
          failures++;
          $display("FAIL bp_data: got %h expected %h", out_data, e);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_f(vals[k]));
        k++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 5 || s < 0) begin
      failures++;
      $display("FAIL bp_count: got %0d results expected 5", got);
    end
  endtask

  task automatic test_random();
    logic [31:0] sp[6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                           32'h80000000, 32'h01000001};
    logic [31:0] e;
    int n = 3000;
    int k = 0;
    int got = 0;
    for (int c = 0; c < 30000 && got < n; c++) begin
      @(negedge clk);
      in_valid = (k < n) && ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) in_data = sp[$urandom_range(0, 5)];
      else in_data = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
        got++;
        checks++;
        if (out_data !== e) begin
          failures++;
          $display("FAIL rand_data: got %h expected %h", out_data, e);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_f(in_data));
        k++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL rand_count: got %0d results expected %0d", got, n);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] vals[3] = '{32'd7, 32'hFFFF0000, 32'd999};
    logic [31:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = vals[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_preload: got %b expected 1", out_valid);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0) begin
      failures++;
      $display("FAIL rst_async: got %b/%h expected 0/0", out_valid, out_data);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_stale: got %b expected 0", out_valid);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 32'hFFFFFC18;
    #1;
    if (in_ready) sb.push_back(ref_f(in_data));
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== (c == 3)) begin
        failures++;
        $display("FAIL rst_recover_lat: cycle %0d out_valid=%b", c, out_valid);
      end
      if (out_valid) begin
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
        checks++;
        if (out_data !== e) begin
          failures++;
          $display("FAIL rst_recover_data: got %h expected %h", out_data, e);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_rounding();
    test_backpressure();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
